bist_input_sel: RTL and testbench
=================================

# bist_input_sel

Parametrised BIST input selector: routes one of `NCH` functional input channels, or the BIST pattern input, onto a registered `WIDTH`-bit bus feeding the circuit under test. Switching between functional and test mode is controlled by a small FSM. The FSM inserts `GUARD` quiet cycles, with the output forced to zero and marked invalid, so the circuit under test never sees a mixed or glitched word. It replaces the fixed 4-bit 2:1 combinational input mux at the front of the BIST datapath.

## Interface
- `WIDTH`, default 4: data width per channel.
- `NCH`, default 2: number of functional channels (≥1; need not be a power of 2).
- `GUARD`, default 2: quiet cycles inserted on every mode switch (≥1).
- `clk`  in  1  rising-edge clock. Single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `func_data`  in  NCH*WIDTH  functional inputs; channel k is bits [k*WIDTH +: WIDTH].
- `func_sel`  in  max(1,$clog2(NCH))  functional channel select.
- `test_data`  in  WIDTH  BIST pattern word.
- `mode_req`  in  1  level request: 1 = test mode, 0 = functional mode.
- `hold`  in  1  freeze `y` (FUNC/TEST states only).
- `y`  out  WIDTH  registered selected data.
- `y_valid`  out  1  `y` carries a valid source word.
- `test_mode`  out  1  state is TEST.
- `mode_ack`  out  1  one-cycle pulse on completing a mode switch.

## Operation
- States: FUNC, DRN_T (draining toward test), TEST, DRN_F (draining toward functional).
- FUNC:
  - `mode_req`=1 → DRN_T, otherwise stay.
  - Each edge loads `y` with channel `func_sel`.
  - If `func_sel` ≥ NCH, load 0 with `y_valid` still 1.
- DRN_T / DRN_F:
  - Guard counter counts GUARD cycles, then the state moves to TEST / FUNC respectively.
  - `y` = 0 and `y_valid` = 0 throughout.
  - `mode_req` and `hold` are ignored; a drain always completes.
- TEST:
  - `mode_req`=0 → DRN_F, otherwise stay.
  - Each edge loads `y` with `test_data`.
- `hold`=1 in FUNC/TEST: `y` retains its value and `y_valid` stays 1. State transitions still take priority over `hold`.
- `mode_ack`: 1 for exactly the first cycle spent in TEST or FUNC after a drain. It is not asserted after reset.
- `test_mode`: 1 iff the state is TEST.
- Request reversal during a drain: the drain finishes into the destination state. That state then sees the opposite `mode_req` and immediately starts the reverse drain. `mode_ack` still pulses for that one cycle.
- Guard counter width: $clog2(GUARD+1). It resets to 0 on each drain entry, with no wrap.

## Timing
- Reset (async assert, synchronous deassert handled upstream):
  - State FUNC, `y`=0, `y_valid`=0, `test_mode`=0, `mode_ack`=0, counter 0.
- First edge after `rst_n` rises: `y` = selected functional channel, `y_valid`=1.
- Data latency: 1 cycle. `y` at cycle n+1 is the source sampled at edge n.
- Switch latency: `mode_req` toggles before edge t → drain state from t for GUARD cycles.
  - At edge t+GUARD, the new state is entered and `y` loads the new source.
  - `y_valid`=1 and `mode_ack`=1 during cycle t+GUARD.
- Reset asserted mid-drain or mid-test: immediate return to the reset values above. No `mode_ack` follows.

## Structure
- Shared BIST package holds:
  - the state enum (FUNC, DRN_T, TEST, DRN_F);
  - the select-width helper function.
- One natural sub-module: `bist_chan_mux`, a parametrised combinational NCH:1 mux with out-of-range → 0. The FSM, guard counter and output register stay in the top.

## Test plan
- Reset/startup: WIDTH=4, NCH=3, GUARD=2; hold `rst_n`=0.
  - During reset: `y`=0, `y_valid`=0.
  - Release with `func_sel`=2 and channel 2 = 4'hA → next cycle `y`=4'hA, `y_valid`=1, no `mode_ack`.
- Out-of-range select: `func_sel`=3 with NCH=3 → `y`=0, `y_valid`=1.
- Switch to test: `mode_req` 0→1 with `test_data`=4'h5.
  - Exactly 2 cycles of `y`=0, `y_valid`=0.
  - Then `y`=4'h5, `test_mode`=1, `mode_ack` high for 1 cycle.
- Reversal mid-drain: drop `mode_req` in the first DRN_T cycle.
  - TEST is entered with `mode_ack`=1 for 1 cycle.
  - DRN_F follows (2 cycles), then FUNC with a second `mode_ack` pulse.
- Hold: in TEST, set `hold`=1 while `test_data` changes 5→C → `y` stays 4'h5. Release → `y`=4'hC one cycle later.
- Async reset mid-drain: assert `rst_n`=0 asynchronously during DRN_T → outputs go to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/bist_input_sel_pkg.sv
// -----------------------------------------------------------------------------
// bist_input_sel_pkg
// Shared definitions for the BIST input selector:
//   - state_t    : mode-switch FSM states (functional, drain to test, test,
//                  drain to functional)
//   - sel_width(): width of a channel select for a given channel count
//                  (never narrower than one bit, so NCH=1 still has a port)
// -----------------------------------------------------------------------------
package bist_input_sel_pkg;

    typedef enum logic [1:0] {
        ST_FUNC  = 2'd0,
        ST_DRN_T = 2'd1,
        ST_TEST  = 2'd2,
        ST_DRN_F = 2'd3
    } state_t;

    function automatic int sel_width(input int nch);
        return (nch <= 1) ? 1 : $clog2(nch);
    endfunction

endpackage

// File: rtl/bist_input_sel_if.sv
// -----------------------------------------------------------------------------
// bist_input_sel_if
// Bundle of data/control signals between the BIST input selector and its
// surroundings.
//   func_data  NCH*WIDTH  functional channels, channel k at [k*WIDTH +: WIDTH]
//   func_sel   SEL_W      functional channel select
//   test_data  WIDTH      BIST pattern word
//   mode_req   1          1 = request test mode, 0 = request functional mode
//   hold       1          freeze y while in FUNC/TEST
//   y          WIDTH      registered selected data
//   y_valid    1          y carries a valid source word
//   test_mode  1          selector is in TEST
//   mode_ack   1          one-cycle pulse when a mode switch completes
// Modports: master drives the inputs and observes the outputs; slave is the
// selector itself.
// -----------------------------------------------------------------------------
interface bist_input_sel_if #(
    parameter int WIDTH = 4,
    parameter int NCH   = 2
) ();
    import bist_input_sel_pkg::*;

    localparam int SEL_W = sel_width(NCH);

    logic [NCH*WIDTH-1:0] func_data;
    logic [SEL_W-1:0]     func_sel;
    logic [WIDTH-1:0]     test_data;
    logic                 mode_req;
    logic                 hold;
    logic [WIDTH-1:0]     y;
    logic                 y_valid;
    logic                 test_mode;
    logic                 mode_ack;

    modport master (
        output func_data, func_sel, test_data, mode_req, hold,
        input  y, y_valid, test_mode, mode_ack
    );

    modport slave (
        input  func_data, func_sel, test_data, mode_req, hold,
        output y, y_valid, test_mode, mode_ack
    );

endinterface

// File: rtl/bist_input_sel_chan_mux.sv
// -----------------------------------------------------------------------------
// bist_chan_mux
// Combinational NCH:1 channel multiplexer.
//   data  in  NCH*WIDTH  packed channels, channel k at [k*WIDTH +: WIDTH]
//   sel   in  SEL_W      channel index
//   out   out WIDTH      selected channel, or zero when sel >= NCH
// -----------------------------------------------------------------------------
module bist_chan_mux
    import bist_input_sel_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int NCH   = 2,
    parameter int SEL_W = sel_width(NCH)
) (
    input  logic [NCH*WIDTH-1:0] data,
    input  logic [SEL_W-1:0]     sel,
    output logic [WIDTH-1:0]     out
);

    logic [WIDTH-1:0] chans [NCH];

    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
        assign chans[gi] = data[gi*WIDTH +: WIDTH];
    end

    // Priority-free match: at most one index can equal sel. Indices that
    // match no channel (non power-of-two NCH) fall through to zero.
    always_comb begin
        out = '0;
        for (int k = 0; k < NCH; k++) begin
            if (int'(sel) == k) begin
                out = chans[k];
            end
        end
    end

endmodule

// File: rtl/bist_input_sel.sv
// -----------------------------------------------------------------------------
// bist_input_sel
// Registered BIST input selector. Routes one functional channel (FUNC) or the
// BIST pattern word (TEST) onto y. Every mode switch passes through a drain
// state lasting GUARD cycles in which y is forced to zero and marked invalid,
// so the circuit under test never sees a word mixed from both sources.
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport of bist_input_sel_if (data, select, mode control,
//               y / y_valid / test_mode / mode_ack outputs)
// Parameters: WIDTH data width, NCH functional channels (>=1),
//             GUARD quiet cycles per switch (>=1).
// -----------------------------------------------------------------------------
module bist_input_sel
    import bist_input_sel_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int NCH   = 2,
    parameter int GUARD = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    bist_input_sel_if.slave  bus
);

    localparam int SEL_W = sel_width(NCH);
    localparam int CNT_W = $clog2(GUARD + 1);
    // Last counter value of a drain; the edge that sees it leaves the drain,
    // so the counter never has to wrap.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GUARD - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg,   cnt_next;
    logic [WIDTH-1:0] y_reg,     y_next;
    logic             valid_reg, valid_next;
    logic             ack_reg,   ack_next;
    logic [WIDTH-1:0] func_word;

    bist_chan_mux #(
        .WIDTH (WIDTH),
        .NCH   (NCH),
        .SEL_W (SEL_W)
    ) u_chan_mux (
        .data (bus.func_data),
        .sel  (bus.func_sel),
        .out  (func_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_FUNC;
            cnt_reg   <= '0;
            y_reg     <= '0;
            valid_reg <= 1'b0;
            ack_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            y_reg     <= y_next;
            valid_reg <= valid_next;
            ack_reg   <= ack_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        y_next     = y_reg;
        valid_next = valid_reg;
        ack_next   = 1'b0;

        case (state_reg)
            ST_FUNC: begin
                if (bus.mode_req) begin
                    // Switch wins over hold: start the drain right away.
                    state_next = ST_DRN_T;
                    cnt_next   = '0;
                    y_next     = '0;
                    valid_next = 1'b0;
                end else begin
                    valid_next = 1'b1;
                    if (!bus.hold) begin
                        y_next = func_word;
                    end
                end
            end

            ST_DRN_T: begin
                if (cnt_reg == CNT_LAST) begin
                    state_next = ST_TEST;
                    cnt_next   = '0;
                    y_next     = bus.test_data;
                    valid_next = 1'b1;
                    ack_next   = 1'b1;
                end else begin
                    cnt_next   = cnt_reg + CNT_W'(1);
                    y_next     = '0;
                    valid_next = 1'b0;
                end
            end

            ST_TEST: begin
                if (!bus.mode_req) begin
                    state_next = ST_DRN_F;
                    cnt_next   = '0;
                    y_next     = '0;
                    valid_next = 1'b0;
                end else begin
                    valid_next = 1'b1;
                    if (!bus.hold) begin
                        y_next = bus.test_data;
                    end
                end
            end

            ST_DRN_F: begin
                if (cnt_reg == CNT_LAST) begin
                    state_next = ST_FUNC;
                    cnt_next   = '0;
                    y_next     = func_word;
                    valid_next = 1'b1;
                    ack_next   = 1'b1;
                end else begin
                    cnt_next   = cnt_reg + CNT_W'(1);
                    y_next     = '0;
                    valid_next = 1'b0;
                end
            end

            default: begin
                state_next = ST_FUNC;
                cnt_next   = '0;
                y_next     = '0;
                valid_next = 1'b0;
            end
        endcase
    end

    assign bus.y         = y_reg;
    assign bus.y_valid   = valid_reg;
    assign bus.test_mode = (state_reg == ST_TEST);
    assign bus.mode_ack  = ack_reg;

endmodule

// File: tb/tb_bist_input_sel.sv
// -----------------------------------------------------------------------------
// tb_bist_input_sel
// Directed bench for bist_input_sel with WIDTH=4, NCH=3, GUARD=2.
// Observations are packed as {y[3:0], y_valid, test_mode, mode_ack}.
// -----------------------------------------------------------------------------
module tb_bist_input_sel;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bist_input_sel_if #(.WIDTH(4), .NCH(3)) bus ();

    bist_input_sel #(
        .WIDTH (4),
        .NCH   (3),
        .GUARD (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [6:0] snap();
        return {bus.y, bus.y_valid, bus.test_mode, bus.mode_ack};
    endfunction

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [6:0] obs;
        bus.func_data = {4'hA, 4'h7, 4'h3};
        bus.func_sel  = 2'd2;
        bus.test_data = 4'h5;
        bus.mode_req  = 1'b0;
        bus.hold      = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        obs = snap();
        checks++;
        if (obs !== {4'h0, 3'b000}) begin
            errors++;
            $display("FAIL reset_assert obs=%h required=%h", obs, {4'h0, 3'b000});
        end
        tick();
        tick();
        obs = snap();
        checks++;
        if (obs !== {4'h0, 3'b000}) begin
            errors++;
            $display("FAIL reset_held obs=%h required=%h", obs, {4'h0, 3'b000});
        end
        rst_n = 1'b1;
        tick();
        obs = snap();
        checks++;
        if (obs !== {4'hA, 3'b100}) begin
            errors++;
            $display("FAIL startup obs=%h required=%h", obs, {4'hA, 3'b100});
        end
        $display("reset/startup: y=%h valid=%b ack=%b", bus.y, bus.y_valid, bus.mode_ack);
    endtask

    task automatic test_select();
        logic [6:0] obs;
        logic [1:0] sels [4] = '{2'd3, 2'd1, 2'd0, 2'd2};
        logic [3:0] exps [4] = '{4'h0, 4'h7, 4'h3, 4'hA};
        for (int i = 0; i < 4; i++) begin
            bus.func_sel = sels[i];
            tick();
            obs = snap();
            checks++;
            if (obs !== {exps[i], 3'b100}) begin
                errors++;
                $display("FAIL select_%0d obs=%h required=%h", sels[i], obs, {exps[i], 3'b100});
            end
            $display("select %0d: y=%h valid=%b", sels[i], bus.y, bus.y_valid);
        end
    endtask

    task automatic test_func_back_to_back();
        logic [6:0] obs;
        logic [3:0] vals [3] = '{4'h1, 4'h2, 4'h3};
        bus.func_sel = 2'd1;
        for (int i = 0; i < 3; i++) begin
            bus.func_data = {4'hA, vals[i], 4'h3};
            tick();
            obs = snap();
            checks++;
            if (obs !== {vals[i], 3'b100}) begin
                errors++;
                $display("FAIL func_stream_%0d obs=%h required=%h", i, obs, {vals[i], 3'b100});
            end
            $display("func stream %0d: y=%h", i, bus.y);
        end
        bus.hold      = 1'b1;
        bus.func_data = {4'hA, 4'h9, 4'h3};
        tick();
        obs = snap();
        checks++;
        if (obs !== {4'h3, 3'b100}) begin
            errors++;
            $display("FAIL func_hold obs=%h required=%h", obs, {4'h3, 3'b100});
        end
        bus.hold = 1'b0;
        tick();
        obs = snap();
        checks++;
        if (obs !== {4'h9, 3'b100}) begin
            errors++;
            $display("FAIL func_release obs=%h required=%h", obs, {4'h9, 3'b100});
        end
        $display("func hold/release: y=%h", bus.y);
        bus.func_data = {4'hA, 4'h7, 4'h3};
    endtask

    task automatic test_switch_to_test();
        logic [6:0] obs;
        logic [6:0] exps [4] = '{{4'h0, 3'b000}, {4'h0, 3'b000},
                                 {4'h5, 3'b111}, {4'h5, 3'b110}};
        bus.test_data = 4'h5;
        bus.mode_req  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            obs = snap();
            checks++;
            if (obs !== exps[i]) begin
                errors++;
                $display("FAIL to_test_cyc%0d obs=%h required=%h", i, obs, exps[i]);
            end
            $display("to test cycle %0d: y=%h valid=%b tm=%b ack=%b",
                     i, bus.y, bus.y_valid, bus.test_mode, bus.mode_ack);
        end
    endtask

    task automatic test_hold();
        logic [6:0] obs;
        bus.hold      = 1'b1;
        bus.test_data = 4'hC;
        for (int i = 0; i < 2; i++) begin
            tick();
            obs = snap();
            checks++;
            if (obs !== {4'h5, 3'b110}) begin
                errors++;
                $display("FAIL test_hold_%0d obs=%h required=%h", i, obs, {4'h5, 3'b110});
            end
        end
        bus.hold = 1'b0;
        tick();
        obs = snap();
        checks++;
        if (obs !== {4'hC, 3'b110}) begin
            errors++;
            $display("FAIL test_release obs=%h required=%h", obs, {4'hC, 3'b110});
        end
        $display("test hold/release: y=%h", bus.y);
    endtask

    task automatic test_to_func();
        logic [6:0] obs;
        logic [6:0] exps [4] = '{{4'h0, 3'b000}, {4'h0, 3'b000},
                                 {4'h7, 3'b101}, {4'h7, 3'b100}};
        bus.func_sel = 2'd1;
        bus.mode_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            obs = snap();
            checks++;
            if (obs !== exps[i]) begin
                errors++;
                $display("FAIL to_func_cyc%0d obs=%h required=%h", i, obs, exps[i]);
            end
            $display("to func cycle %0d: y=%h valid=%b tm=%b ack=%b",
                     i, bus.y, bus.y_valid, bus.test_mode, bus.mode_ack);
        end
    endtask

    task automatic test_reversal();
        logic [6:0] obs;
        logic [6:0] exps [7] = '{{4'h0, 3'b000},   // DRN_T 1
                                 {4'h0, 3'b000},   // DRN_T 2
                                 {4'hC, 3'b111},   // TEST, ack
                                 {4'h0, 3'b000},   // DRN_F 1
                                 {4'h0, 3'b000},   // DRN_F 2
                                 {4'h7, 3'b101},   // FUNC, ack
                                 {4'h7, 3'b100}};  // FUNC
        bus.mode_req = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (i == 0) bus.mode_req = 1'b0;
            obs = snap();
            checks++;
            if (obs !== exps[i]) begin
                errors++;
                $display("FAIL reversal_cyc%0d obs=%h required=%h", i, obs, exps[i]);
            end
            $display("reversal cycle %0d: y=%h valid=%b tm=%b ack=%b",
                     i, bus.y, bus.y_valid, bus.test_mode, bus.mode_ack);
        end
    endtask

    task automatic test_async_reset();
        logic [6:0] obs;
        // Reset while in TEST carrying data.
        bus.mode_req = 1'b1;
        repeat (3) tick();
        obs = snap();
        checks++;
        if (obs !== {4'hC, 3'b111}) begin
            errors++;
            $display("FAIL pre_reset_test obs=%h required=%h", obs, {4'hC, 3'b111});
        end
        #3 rst_n = 1'b0;
        #1;
        obs = snap();
        checks++;
        if (obs !== {4'h0, 3'b000}) begin
            errors++;
            $display("FAIL async_reset_test obs=%h required=%h", obs, {4'h0, 3'b000});
        end
        bus.mode_req = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        obs = snap();
        checks++;
        if (obs !== {4'h7, 3'b100}) begin
            errors++;
            $display("FAIL after_reset_test obs=%h required=%h", obs, {4'h7, 3'b100});
        end
        // Reset in the second DRN_T cycle; the next drain must last a full GUARD.
        bus.mode_req = 1'b1;
        tick();
        tick();
        #3 rst_n = 1'b0;
        #1;
        obs = snap();
        checks++;
        if (obs !== {4'h0, 3'b000}) begin
            errors++;
            $display("FAIL async_reset_drain obs=%h required=%h", obs, {4'h0, 3'b000});
        end
        bus.mode_req = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        obs = snap();
        checks++;
        if (obs !== {4'h7, 3'b100}) begin
            errors++;
            $display("FAIL after_reset_drain obs=%h required=%h", obs, {4'h7, 3'b100});
        end
        bus.mode_req = 1'b1;
        tick();
        tick();
        obs = snap();
        checks++;
        if (obs !== {4'h0, 3'b000}) begin
            errors++;
            $display("FAIL drain_restart obs=%h required=%h", obs, {4'h0, 3'b000});
        end
        tick();
        obs = snap();
        checks++;
        if (obs !== {4'hC, 3'b111}) begin
            errors++;
            $display("FAIL drain_restart_done obs=%h required=%h", obs, {4'hC, 3'b111});
        end
        $display("async reset: y=%h valid=%b tm=%b ack=%b",
                 bus.y, bus.y_valid, bus.test_mode, bus.mode_ack);
    endtask

    initial begin
        test_reset();
        test_select();
        test_func_back_to_back();
        test_switch_to_test();
        test_hold();
        test_to_func();
        test_reversal();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
